// File: rtl/mult32_seq_pkg.sv
// rtl/mult32_seq_pkg.sv - shared state encodings, iteration count and helpers for mult32_seq
// Purpose: state encodings (2 bits), iteration count, and the
//          32-bit magnitude helper used by the signed multiply path.
// Ports:   none (package)
package mult32_seq_pkg;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_e;

  localparam int MULT_ITER = 32;

  // Magnitude of a two's complement word. 0x80000000 maps to itself, which
  // is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mult32_seq_adder32.sv
// rtl/mult32_seq_adder32.sv - 32-bit ripple-style adder with carry in/out
// Purpose: plain 32-bit adder, reused once per multiplier iteration.
// Ports:   a_i/b_i [31:0] operands, c_in_i carry in,
//          sum_o [31:0] sum, c_out_o carry out.
module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_in_i,
  output logic [31:0] sum_o,
  output logic        c_out_o
);

  assign {c_out_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, c_in_i};

endmodule

// File: rtl/mult32_seq.sv
// rtl/mult32_seq.sv - multi-cycle 32x32->64 shift-and-add multiplier
// Purpose: sequential multiplier for the execute stage; one adder32 is
//          reused for each of the 32 iterations.
// Ports:   clk_i clock, rst_ni async active-low reset,
//          start_i request (sampled in IDLE/DONE), a_i/b_i [31:0] operands,
//          busy_o high while iterating, done_o one-cycle completion,
//          product_o [63:0] result held until the next accepted start.
module mult32_seq
  import mult32_seq_pkg::*;
#(
  parameter bit SIGNED    = 1'b0,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);

  mult_state_e state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q,  mplr_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic        neg_q,   neg_d;
  logic [63:0] product_q, product_d;

  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_c_out;
  logic [63:0] iter_acc;
  logic        accept;
  logic        zero_op;

  assign add_b = mplr_q[0] ? mcand_q : 32'd0;

  adder32 u_add (
    .a_i    (acc_hi_q),
    .b_i    (add_b),
    .c_in_i (1'b0),
    .sum_o  (add_sum),
    .c_out_o(add_c_out)
  );

  // Shift the 33-bit adder result into the top of the accumulator while the
  // consumed multiplier bit falls off the bottom; c_out is retained.
  assign iter_acc = {add_c_out, add_sum, mplr_q[31:1]};

  assign accept  = start_i && ((state_q == MULT_IDLE) || (state_q == MULT_DONE));
  assign zero_op = ZERO_SKIP && ((a_i == 32'd0) || (b_i == 32'd0));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_hi_d  = acc_hi_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      MULT_IDLE, MULT_DONE: begin
        if (accept) begin
          count_d  = 5'd0;
          acc_hi_d = 32'd0;
          if (zero_op) begin
            state_d   = MULT_DONE;
            product_d = 64'd0;
            mcand_d   = 32'd0;
            mplr_d    = 32'd0;
            neg_d     = 1'b0;
          end else begin
            state_d = MULT_RUN;
            mcand_d = SIGNED ? abs32(a_i) : a_i;
            mplr_d  = SIGNED ? abs32(b_i) : b_i;
            neg_d   = SIGNED && (a_i[31] ^ b_i[31]);
          end
        end else begin
          state_d = MULT_IDLE;
        end
      end
      MULT_RUN: begin
        {acc_hi_d, mplr_d} = iter_acc;
        count_d = count_q + 5'd1;
        if (count_q == 5'(MULT_ITER - 1)) begin
          state_d   = MULT_DONE;
          product_d = neg_q ? (~iter_acc + 64'd1) : iter_acc;
        end
      end
      default: state_d = MULT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= MULT_IDLE;
      count_q   <= 5'd0;
      mcand_q   <= 32'd0;
      mplr_q    <= 32'd0;
      acc_hi_q  <= 32'd0;
      neg_q     <= 1'b0;
      product_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_hi_q  <= acc_hi_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy_o    = (state_q == MULT_RUN);
  assign done_o    = (state_q == MULT_DONE);
  assign product_o = product_q;

endmodule

// File: tb/tb_mult32_seq.sv
// tb/tb_mult32_seq.sv - self-checking bench for mult32_seq (unsigned and signed instances)
module tb_mult32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy_u, done_u, busy_s, done_s;
  logic [63:0] prod_u, prod_s;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mult32_seq #(.SIGNED(1'b0), .ZERO_SKIP(1'b1)) dut_u (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy_u), .done_o(done_u), .product_o(prod_u)
  );

  mult32_seq #(.SIGNED(1'b1), .ZERO_SKIP(1'b1)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy_s), .done_o(done_s), .product_o(prod_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model_u(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  function automatic logic [63:0] model_s(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    return sx * sy;
  endfunction

  // Called on a falling edge. Starts one multiply; returns the number of
  // rising edges from the start request until done is seen (1 for the
  // accepting edge itself), the cycles busy was seen, a flag for busy&done
  // overlap or disagreement between the two instances, and both products.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        output int lat, output int bcyc, output bit bad,
                        output logic [63:0] pu, output logic [63:0] ps);
    lat = 0; bcyc = 0; bad = 1'b0;
    a = op_a; b = op_b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if ((busy_u && done_u) || (busy_u !== busy_s) || (done_u !== done_s)) bad = 1'b1;
      if (done_u === 1'b1) begin
        lat = k;
        break;
      end
      if (busy_u === 1'b1) bcyc++;
      @(negedge clk);
    end
    pu = prod_u;
    ps = prod_s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({busy_u, done_u, prod_u} !== 66'd0) $display("FAIL reset_u: got busy=%b done=%b prod=%h want 0", busy_u, done_u, prod_u);
    else pass_cnt++;
    chk_cnt++;
    if ({busy_s, done_s, prod_s} !== 66'd0) $display("FAIL reset_s: got busy=%b done=%b prod=%h want 0", busy_s, done_s, prod_s);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known();
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [63:0] eu [6];
    logic [63:0] es [6];
    int lat, bcyc;
    bit bad;
    logic [63:0] pu, ps;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; eu[0] = 64'hFFFF_FFFE_0000_0001; es[0] = 64'h1;
    ta[1] = 32'h8000_0000; tb[1] = 32'h4000_0000; eu[1] = 64'h2000_0000_0000_0000; es[1] = 64'hE000_0000_0000_0000;
    ta[2] = 32'hFFFF_FFF9; tb[2] = 32'd6;         eu[2] = 64'h0000_0005_FFFF_FFD6; es[2] = 64'hFFFF_FFFF_FFFF_FFD6;
    ta[3] = 32'h8000_0000; tb[3] = 32'h8000_0000; eu[3] = 64'h4000_0000_0000_0000; es[3] = 64'h4000_0000_0000_0000;
    ta[4] = 32'h8000_0000; tb[4] = 32'd1;         eu[4] = 64'h0000_0000_8000_0000; es[4] = 64'hFFFF_FFFF_8000_0000;
    ta[5] = 32'd3;         tb[5] = 32'd5;         eu[5] = 64'd15;                  es[5] = 64'd15;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_op(ta[i], tb[i], lat, bcyc, bad, pu, ps);
      chk_cnt++;
      if (lat != 33) $display("FAIL known%0d_latency: got %0d want 33", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if (bcyc != 32) $display("FAIL known%0d_busy_cycles: got %0d want 32", i, bcyc);
      else pass_cnt++;
      chk_cnt++;
      if (bad) $display("FAIL known%0d_handshake: got overlap/instance mismatch want none", i);
      else pass_cnt++;
      chk_cnt++;
      if (pu !== eu[i]) $display("FAIL known%0d_unsigned: got %h want %h", i, pu, eu[i]);
      else pass_cnt++;
      chk_cnt++;
      if (ps !== es[i]) $display("FAIL known%0d_signed: got %h want %h", i, ps, es[i]);
      else pass_cnt++;
    end
    // Result must hold through idle cycles.
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy_u, done_u, prod_u} !== {2'b00, 64'd15}) $display("FAIL hold_idle: got busy=%b done=%b prod=%h want 0 0 f", busy_u, done_u, prod_u);
    else pass_cnt++;
  endtask

  task automatic test_zero_skip();
    int lat, bcyc;
    bit bad;
    logic [63:0] pu, ps;
    logic [31:0] za [2];
    logic [31:0] zb [2];
    za[0] = 32'd0;         zb[0] = 32'h1234;
    za[1] = 32'hDEAD_BEEF; zb[1] = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      run_op(za[i], zb[i], lat, bcyc, bad, pu, ps);
      chk_cnt++;
      if (lat != 1) $display("FAIL zero%0d_latency: got %0d want 1", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if (bcyc != 0 || bad) $display("FAIL zero%0d_busy: got busy_cycles=%0d bad=%0b want 0 0", i, bcyc, bad);
      else pass_cnt++;
      chk_cnt++;
      if ({pu, ps} !== 128'd0) $display("FAIL zero%0d_product: got %h %h want 0", i, pu, ps);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat, bcyc;
    bit bad;
    logic [63:0] pu, ps;
    logic [31:0] ra, rb;
    bit zero;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'd0;
      if ($urandom_range(0, 3) == 0) ra = {1'b1, ra[30:0]};
      if ($urandom_range(0, 3) == 0) rb = {1'b1, rb[30:0]};
      zero = (ra == 32'd0) || (rb == 32'd0);
      @(negedge clk);
      run_op(ra, rb, lat, bcyc, bad, pu, ps);
      chk_cnt++;
      if (lat != (zero ? 1 : 33) || bcyc != (zero ? 0 : 32) || bad)
        $display("FAIL rand%0d_timing: got lat=%0d busy=%0d bad=%0b want lat=%0d busy=%0d", i, lat, bcyc, bad, zero ? 1 : 33, zero ? 0 : 32);
      else pass_cnt++;
      chk_cnt++;
      if (pu !== model_u(ra, rb)) $display("FAIL rand%0d_unsigned: %h*%h got %h want %h", i, ra, rb, pu, model_u(ra, rb));
      else pass_cnt++;
      chk_cnt++;
      if (ps !== model_s(ra, rb)) $display("FAIL rand%0d_signed: %h*%h got %h want %h", i, ra, rb, ps, model_s(ra, rb));
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] ia, ib;
    int lat;
    ia = 32'h0001_2345;
    ib = 32'hFFFF_FF00;
    lat = 0;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 32'h7777_7777; b = 32'h0000_0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 7; k <= 40; k++) begin
      if (done_u === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk_cnt++;
    if (lat != 33) $display("FAIL ignore_latency: got %0d want 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (prod_u !== model_u(ia, ib)) $display("FAIL ignore_unsigned: got %h want %h", prod_u, model_u(ia, ib));
    else pass_cnt++;
    chk_cnt++;
    if (prod_s !== model_s(ia, ib)) $display("FAIL ignore_signed: got %h want %h", prod_s, model_s(ia, ib));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bcyc;
    bit bad;
    logic [63:0] pu, ps;
    logic [31:0] x1, y1, x2, y2;
    x1 = $urandom | 32'd1; y1 = $urandom | 32'd1;
    x2 = $urandom | 32'd2; y2 = $urandom | 32'd2;
    @(negedge clk);
    run_op(x1, y1, lat, bcyc, bad, pu, ps);
    chk_cnt++;
    if (lat != 33 || pu !== model_u(x1, y1) || ps !== model_s(x1, y1))
      $display("FAIL b2b_first: got lat=%0d %h %h want 33 %h %h", lat, pu, ps, model_u(x1, y1), model_s(x1, y1));
    else pass_cnt++;
    // Still in the DONE cycle: the next request is accepted immediately.
    run_op(x2, y2, lat, bcyc, bad, pu, ps);
    chk_cnt++;
    if (lat != 33 || bcyc != 32 || bad) $display("FAIL b2b_timing: got lat=%0d busy=%0d bad=%0b want 33 32 0", lat, bcyc, bad);
    else pass_cnt++;
    chk_cnt++;
    if (pu !== model_u(x2, y2) || ps !== model_s(x2, y2))
      $display("FAIL b2b_second: got %h %h want %h %h", pu, ps, model_u(x2, y2), model_s(x2, y2));
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int lat, bcyc;
    bit bad;
    logic [63:0] pu, ps;
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h9ABC_DEF1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy_u, done_u, prod_u} !== 66'd0) $display("FAIL async_rst_u: got busy=%b done=%b prod=%h want 0", busy_u, done_u, prod_u);
    else pass_cnt++;
    chk_cnt++;
    if ({busy_s, done_s, prod_s} !== 66'd0) $display("FAIL async_rst_s: got busy=%b done=%b prod=%h want 0", busy_s, done_s, prod_s);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd3, 32'd5, lat, bcyc, bad, pu, ps);
    chk_cnt++;
    if (lat != 33 || pu !== 64'd15 || ps !== 64'd15) $display("FAIL after_rst: got lat=%0d %h %h want 33 f f", lat, pu, ps);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_known();
    test_zero_skip();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
